// File: rtl/endian_swap_stream.sv
// rtl/endian_swap_stream.sv - streaming byte-order converter with main+skid output buffer
// Optional transfer counter is built when ENDIAN_SWAP_CNT_EN is defined.
module endian_swap_stream #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef ENDIAN_SWAP_CNT_EN
   ,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   localparam int B = DATA_W / 8;
   localparam int H = DATA_W / 16;

   if ((DATA_W % 16) != 0 || DATA_W < 16 || CNT_W < 1) begin : g_param_check
      $error("endian_swap_stream: DATA_W must be a multiple of 16 (>=16) and CNT_W >= 1");
   end

   logic [DATA_W-1:0] swapped;
   logic [DATA_W-1:0] skid_data;
   logic              accept;

   assign accept = in_valid && in_ready;

   always_comb begin
      swapped = in_data;
      case (in_mode)
         2'b01: begin
            for (int n = 0; n < B; n++)
               swapped[8*n +: 8] = in_data[8*(B-1-n) +: 8];
         end
         2'b10: begin
            for (int n = 0; n < H; n++)
               swapped[16*n +: 16] = in_data[16*(H-1-n) +: 16];
         end
         2'b11: begin
            for (int n = 0; n < H; n++) begin
               swapped[16*n     +: 8] = in_data[16*n + 8 +: 8];
               swapped[16*n + 8 +: 8] = in_data[16*n     +: 8];
            end
         end
         default: swapped = in_data;
      endcase
   end

   // in_ready doubles as the "skid empty" flag, so it never depends on out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
         in_ready  <= 1'b1;
      end else begin
         if (!out_valid || out_ready) begin
            if (!in_ready) begin
               out_data  <= skid_data;
               out_valid <= 1'b1;
               in_ready  <= 1'b1;
            end else if (accept) begin
               out_data  <= swapped;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_data <= swapped;
            in_ready  <= 1'b0;
         end
      end
   end

`ifdef ENDIAN_SWAP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (cnt_clr)
         xfer_cnt <= '0;
      else if (out_valid && out_ready)
         xfer_cnt <= xfer_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_endian_swap_stream.sv
// tb/tb_endian_swap_stream.sv - self-checking bench for endian_swap_stream
// Counter checks are compiled when ENDIAN_SWAP_CNT_EN is defined.
module tb_endian_swap_stream;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int NWORDS = 10000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [1:0]    in_mode = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
`ifdef ENDIAN_SWAP_CNT_EN
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] xfer_cnt;
`endif

   int tests = 0;
   int fails = 0;

   endian_swap_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_mode(in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef ENDIAN_SWAP_CNT_EN
      ,
      .cnt_clr(cnt_clr),
      .xfer_cnt(xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  mode;
      logic [31:0] exp;
   } vec_t;

   // Reference: each output byte n is taken from an input byte chosen by the mode's index rule.
   function automatic logic [31:0] ref_swap(logic [31:0] d, logic [1:0] m);
      logic [31:0] r;
      int src;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         case (m)
            2'b00:   src = n;
            2'b01:   src = 3 - n;
            2'b10:   src = 2 * (1 - n / 2) + n % 2;
            default: src = n ^ 1;
         endcase
         r[8*n +: 8] = d[8*src +: 8];
      end
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[8];
   logic [31:0] q[$];
   logic [31:0] held;
   logic [31:0] front;
   logic        stall_prev;
   int sent, recv, cycles;

   initial begin
      vecs[0] = '{32'h12345678, 2'b00, 32'h12345678};
      vecs[1] = '{32'h12345678, 2'b01, 32'h78563412};
      vecs[2] = '{32'h12345678, 2'b10, 32'h56781234};
      vecs[3] = '{32'h12345678, 2'b11, 32'h34127856};
      vecs[4] = '{32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
      vecs[5] = '{32'hDEADBEEF, 2'b01, 32'hEFBEADDE};
      vecs[6] = '{32'hDEADBEEF, 2'b10, 32'hBEEFDEAD};
      vecs[7] = '{32'hDEADBEEF, 2'b11, 32'hADDEEFBE};

      step();
      step();
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_data", out_data, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ENDIAN_SWAP_CNT_EN
      check("reset xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // Mode table, one word at a time
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[i].data;
         in_mode  = vecs[i].mode;
         step();
         in_valid = 1'b0;
         check("mode out_valid", {31'd0, out_valid}, 32'd1);
         check("mode out_data", out_data, vecs[i].exp);
         step();
      end

      // Back-to-back stream
      in_valid = 1'b1; in_data = 32'h87654321; in_mode = 2'b01;
      step();
      check("b2b word1", out_data, 32'h21436587);
      check("b2b ready1", {31'd0, in_ready}, 32'd1);
      in_data = 32'hA1B2C3D4; in_mode = 2'b10;
      step();
      in_valid = 1'b0;
      check("b2b word2", out_data, 32'hC3D4A1B2);
      check("b2b valid2", {31'd0, out_valid}, 32'd1);
      check("b2b ready2", {31'd0, in_ready}, 32'd1);
      step();
      check("b2b drained", {31'd0, out_valid}, 32'd0);

      // Backpressure: three words against a stalled sink
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h0000_0001;
      step();
      check("bp ready after w1", {31'd0, in_ready}, 32'd1);
      in_data = 32'h0000_0002;
      step();
      check("bp ready after w2", {31'd0, in_ready}, 32'd0);
      check("bp main w1", out_data, 32'h0000_0001);
      in_data = 32'h0000_0003;
      step();
      check("bp w3 held", {31'd0, in_ready}, 32'd0);
      check("bp main stable", out_data, 32'h0000_0001);
      out_ready = 1'b1;
      step();
      check("bp release w2", out_data, 32'h0000_0002);
      check("bp release ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp w3 out", out_data, 32'h0000_0003);
      check("bp w3 valid", {31'd0, out_valid}, 32'd1);
      step();
      check("bp empty", {31'd0, out_valid}, 32'd0);

`ifdef ENDIAN_SWAP_CNT_EN
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("cnt cleared", {28'd0, xfer_cnt}, 32'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = i;
         step();
      end
      in_valid = 1'b0;
      step();
      check("cnt wrap 17", {28'd0, xfer_cnt}, 32'd1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("cnt clr wins", {28'd0, xfer_cnt}, 32'd0);
      step();
`endif

      // Random traffic against the scoreboard
      sent = 0; recv = 0; cycles = 0;
      stall_prev = 1'b0; held = '0;
      while (recv < NWORDS && cycles < 60000) begin
         in_valid  = (sent < NWORDS) && ($urandom_range(3) != 0);
         in_data   = $urandom;
         in_mode   = 2'($urandom_range(3));
         out_ready = ($urandom_range(3) != 0);
         check("rand occupancy", {30'd0, out_valid, in_ready},
               {30'd0, q.size() > 0, q.size() < 2});
         if (stall_prev)
            check("rand stall stable", out_data, held);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rand spurious word", 32'd1, 32'd0);
            end else begin
               front = q.pop_front();
               check("rand data", out_data, front);
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_swap(in_data, in_mode));
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         held = out_data;
         step();
         cycles++;
      end
      check("rand completed", recv, NWORDS);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      // Reset with main and skid both full
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b01; in_data = 32'hCAFEF00D;
      step();
      in_data = 32'h0BADBEEF;
      step();
      in_valid = 1'b0;
      check("pre-reset full", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", {31'd0, out_valid}, 32'd0);
      check("async rst out_data", out_data, 32'd0);
      check("async rst in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ENDIAN_SWAP_CNT_EN
      check("async rst xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("no stale word", {31'd0, out_valid}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
